// File: rtl/audio_bar_renderer_pkg.sv
// Shared types and defaults for the spectrum-bar pixel stage.
package audio_bar_renderer_pkg;

   // Default geometry and widths; the top module exposes them as parameters.
   localparam int DEFAULT_SCREEN_HEIGHT = 480;
   localparam int DEFAULT_COORD_WIDTH   = 16;
   localparam int DEFAULT_NUM_BARS      = 16;
   localparam int DEFAULT_BAR_WIDTH     = 40;
   localparam int DEFAULT_BAR_GAP       = 4;
   localparam int DEFAULT_MAG_WIDTH     = 9;
   localparam int DEFAULT_IDX_WIDTH     = 4;

   // Clocks from generator row/col/syncs to the VGA pins. The pixel path
   // is built as exactly two stages, so this value must stay at 2.
   localparam int PIPE_LATENCY = 2;

   // 12-bit RGB as it leaves the chip.
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t BLACK    = '{r: 4'h0, g: 4'h0, b: 4'h0};
   // Lower three quarters of the screen: green.
   localparam rgb_t BAR_LOW  = '{r: 4'h0, g: 4'hF, b: 4'h0};
   // Top quarter of the screen: red.
   localparam rgb_t BAR_HIGH = '{r: 4'hF, g: 4'h0, b: 4'h0};

   // Sync/enable bundle carried alongside the pixel data.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   // Inactive syncs (active-low) and blanked data enable.
   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/audio_bar_renderer_bank.sv
// Double-buffered magnitude store: the writer fills the shadow bank, a
// commit arms a swap, and the swap happens only on the next frame pulse so
// a frame is always drawn from one consistent spectrum.
module bar_bank_pingpong
   import audio_bar_renderer_pkg::*;
#(
   parameter int NUM_BARS  = DEFAULT_NUM_BARS,
   parameter int MAG_WIDTH = DEFAULT_MAG_WIDTH,
   parameter int IDX_WIDTH = DEFAULT_IDX_WIDTH
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 i_wr_en,
   input  logic [IDX_WIDTH-1:0] i_wr_idx,
   input  logic [MAG_WIDTH-1:0] i_wr_mag,
   input  logic                 i_commit,
   input  logic                 i_frame_pulse,
   input  logic [IDX_WIDTH:0]   i_rd_idx,
   output logic [MAG_WIDTH-1:0] o_rd_mag,
   output logic                 o_swap_pending,
   output logic                 o_active_bank
);

   localparam int RDW = IDX_WIDTH + 1;

   logic [MAG_WIDTH-1:0] r_bank [2][NUM_BARS];
   logic                 r_active;
   logic                 r_swap_pending;

   logic w_swap;
   logic w_wr_bank;
   logic w_wr_ok;
   logic w_rd_ok;

   // A swap is a frame pulse that finds a commit waiting.
   assign w_swap = i_frame_pulse & r_swap_pending;

   // Writes go to whichever bank is shadow after this edge, so a write
   // coinciding with a swap lands in the bank that was active until now.
   assign w_wr_bank = w_swap ? r_active : ~r_active;

   // Indices past the last bar are dropped (compare is widened by one bit
   // so it still means something when NUM_BARS fills the index range).
   assign w_wr_ok = i_wr_en && ({1'b0, i_wr_idx} < RDW'(NUM_BARS));

   // Shadow-bank write port; both banks clear on reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_BARS; i++) begin
               r_bank[b][i] <= '0;
            end
         end
      end else if (w_wr_ok) begin
         r_bank[w_wr_bank][i_wr_idx] <= i_wr_mag;
      end
   end

   // Commit/swap control: a commit on the swap cycle re-arms for next frame.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_active       <= 1'b0;
         r_swap_pending <= 1'b0;
      end else begin
         if (w_swap) begin
            r_active <= ~r_active;
         end
         if (i_commit) begin
            r_swap_pending <= 1'b1;
         end else if (w_swap) begin
            r_swap_pending <= 1'b0;
         end
      end
   end

   // Combinational read of the active bank; the saturated "past the last
   // bar" index reads as zero.
   always_comb begin
      w_rd_ok  = i_rd_idx < RDW'(NUM_BARS);
      o_rd_mag = '0;
      if (w_rd_ok) begin
         o_rd_mag = r_bank[r_active][i_rd_idx[IDX_WIDTH-1:0]];
      end
   end

   assign o_swap_pending = r_swap_pending;
   assign o_active_bank  = r_active;

endmodule

// File: rtl/audio_bar_renderer.sv
// Spectrum-bar renderer sitting behind the VGA timing generator. Two
// register stages: stage 1 tracks the bar slot and pixel offset with a
// counter (no divide), stage 2 looks up the magnitude and picks a colour.
// Syncs and data enable ride through the same two stages bit-exact.
module audio_bar_renderer
   import audio_bar_renderer_pkg::*;
#(
   parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
   parameter int COORD_WIDTH   = DEFAULT_COORD_WIDTH,
   parameter int NUM_BARS      = DEFAULT_NUM_BARS,
   parameter int BAR_WIDTH     = DEFAULT_BAR_WIDTH,
   parameter int BAR_GAP       = DEFAULT_BAR_GAP,
   parameter int MAG_WIDTH     = DEFAULT_MAG_WIDTH,
   parameter int IDX_WIDTH     = DEFAULT_IDX_WIDTH
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic signed [COORD_WIDTH-1:0] row,
   input  logic signed [COORD_WIDTH-1:0] col,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   input  logic                          de_in,
   input  logic                          frame_pulse,
   input  logic                          bin_wr_en,
   input  logic [IDX_WIDTH-1:0]          bin_wr_idx,
   input  logic [MAG_WIDTH-1:0]          bin_wr_mag,
   input  logic                          bin_commit,
   output logic                          swap_pending,
   output logic [3:0]                    vga_r,
   output logic [3:0]                    vga_g,
   output logic [3:0]                    vga_b,
   output logic                          hsync,
   output logic                          vsync,
   output logic                          de
);

   localparam int PX_W  = $clog2(BAR_WIDTH);
   // One extra bit so the bar counter can park at NUM_BARS past the last slot.
   localparam int BAR_W = IDX_WIDTH + 1;
   // Row arithmetic is done one bit wider than the coordinate, signed.
   localparam int CW1   = COORD_WIDTH + 1;

   // Stage 1 state.
   logic [PX_W-1:0]               r_px_s1;
   logic [BAR_W-1:0]              r_bar_s1;
   logic signed [COORD_WIDTH-1:0] r_row_s1;
   // Sync pipeline: entry 0 is stage 1, last entry drives the pins.
   sync_t                         r_sync [PIPE_LATENCY];
   // Stage 2 state.
   rgb_t                          r_rgb;

   logic [PX_W-1:0]               w_px_nxt;
   logic [BAR_W-1:0]              w_bar_nxt;
   logic [MAG_WIDTH-1:0]          w_rd_mag;
   logic [MAG_WIDTH-1:0]          w_mag;
   logic signed [CW1-1:0]         w_row_ext;
   logic signed [CW1-1:0]         w_thresh;
   logic                          w_lit;
   rgb_t                          w_colour;
   logic                          w_active_bank;

   // Next pixel offset / bar slot: restart at col 0, roll into the next
   // slot at the end of each one, and stop counting bars at NUM_BARS.
   always_comb begin
      w_px_nxt  = r_px_s1 + 1'b1;
      w_bar_nxt = r_bar_s1;
      if (col == '0) begin
         w_px_nxt  = '0;
         w_bar_nxt = '0;
      end else if (r_px_s1 == PX_W'(BAR_WIDTH - 1)) begin
         w_px_nxt = '0;
         if (r_bar_s1 != BAR_W'(NUM_BARS)) begin
            w_bar_nxt = r_bar_s1 + 1'b1;
         end
      end
   end

   // Stage 1 coordinate registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_px_s1  <= '0;
         r_bar_s1 <= '0;
         r_row_s1 <= '0;
      end else begin
         r_px_s1  <= w_px_nxt;
         r_bar_s1 <= w_bar_nxt;
         r_row_s1 <= row;
      end
   end

   // Sync/enable delay line, reset to inactive levels.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PIPE_LATENCY; i++) begin
            r_sync[i] <= SYNC_IDLE;
         end
      end else begin
         r_sync[0] <= '{hs: hsync_in, vs: vsync_in, de: de_in};
         for (int i = 1; i < PIPE_LATENCY; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   bar_bank_pingpong #(
      .NUM_BARS  (NUM_BARS),
      .MAG_WIDTH (MAG_WIDTH),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_bank (
      .clk            (clk),
      .resetn         (resetn),
      .i_wr_en        (bin_wr_en),
      .i_wr_idx       (bin_wr_idx),
      .i_wr_mag       (bin_wr_mag),
      .i_commit       (bin_commit),
      .i_frame_pulse  (frame_pulse),
      .i_rd_idx       (r_bar_s1),
      .o_rd_mag       (w_rd_mag),
      .o_swap_pending (swap_pending),
      .o_active_bank  (w_active_bank)
   );

   // Magnitude clamp and lit decision: a bar of height mag covers the
   // bottom mag rows, i.e. rows SCREEN_HEIGHT-mag .. SCREEN_HEIGHT-1.
   always_comb begin
      w_mag = w_rd_mag;
      if (w_rd_mag > MAG_WIDTH'(SCREEN_HEIGHT)) begin
         w_mag = MAG_WIDTH'(SCREEN_HEIGHT);
      end
      w_row_ext = $signed({r_row_s1[COORD_WIDTH-1], r_row_s1});
      w_thresh  = $signed(CW1'(SCREEN_HEIGHT) - CW1'(w_mag));
      w_lit     = r_sync[0].de
                  && (r_bar_s1 < BAR_W'(NUM_BARS))
                  && (r_px_s1 < PX_W'(BAR_WIDTH - BAR_GAP))
                  && (w_mag != '0)
                  && (w_row_ext >= w_thresh);
   end

   // Colour pick: top quarter of the screen red, rest green, else black.
   always_comb begin
      w_colour = BLACK;
      if (w_lit) begin
         if (w_row_ext < $signed(CW1'(SCREEN_HEIGHT / 4))) begin
            w_colour = BAR_HIGH;
         end else begin
            w_colour = BAR_LOW;
         end
      end
   end

   // Stage 2 colour register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rgb <= BLACK;
      end else begin
         r_rgb <= w_colour;
      end
   end

   assign vga_r = r_rgb.r;
   assign vga_g = r_rgb.g;
   assign vga_b = r_rgb.b;
   assign hsync = r_sync[PIPE_LATENCY-1].hs;
   assign vsync = r_sync[PIPE_LATENCY-1].vs;
   assign de    = r_sync[PIPE_LATENCY-1].de;

   // Bank select is internal bookkeeping; fold it into an unused sink.
   logic w_unused;
   assign w_unused = w_active_bank;

endmodule

// File: tb/tb_audio_bar_renderer.sv
// Bench for audio_bar_renderer: a compact timing generator (selected lines
// of 664 pixels, 640 active), directed and random bin traffic, and a
// frame-level reference model of the two magnitude buffers.
module tb_audio_bar_renderer;
   import audio_bar_renderer_pkg::*;

   localparam int LINE_LEN = 664;
   localparam int NROWS    = 8;

   // ---------------- clock / reset ----------------
   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic signed [15:0] row;
   logic signed [15:0] col;
   logic               hsync_in, vsync_in, de_in, frame_pulse;
   logic               bin_wr_en;
   logic [3:0]         bin_wr_idx;
   logic [8:0]         bin_wr_mag;
   logic               bin_commit;
   logic               swap_pending;
   logic [3:0]         vga_r, vga_g, vga_b;
   logic               hsync, vsync, de;

   always #5 clk = ~clk;

   audio_bar_renderer dut (
      .clk          (clk),
      .resetn       (resetn),
      .row          (row),
      .col          (col),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .de_in        (de_in),
      .frame_pulse  (frame_pulse),
      .bin_wr_en    (bin_wr_en),
      .bin_wr_idx   (bin_wr_idx),
      .bin_wr_mag   (bin_wr_mag),
      .bin_commit   (bin_commit),
      .swap_pending (swap_pending),
      .vga_r        (vga_r),
      .vga_g        (vga_g),
      .vga_b        (vga_b),
      .hsync        (hsync),
      .vsync        (vsync),
      .de           (de)
   );

   // ---------------- reference model ----------------
   int            shown[16];     // spectrum currently on screen
   int            pending[16];   // spectrum being assembled by the writer
   bit            m_pend;
   logic [14:0]   exp_q[$];      // {rgb, hsync, vsync, de} per input cycle
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         shown[i]   = 0;
         pending[i] = 0;
      end
      m_pend = 1'b0;
      exp_q.delete();
   endtask

   // Colour for one pixel from the spectrum on screen, straight from the
   // geometry: slot = col/40, the last 4 pixels of a slot are gap, a bar of
   // height m fills the bottom m rows, top 120 rows red, rest green.
   function automatic logic [11:0] ref_rgb(input int r, input int c, input bit dv);
      int bar, px, m;
      if (!dv) return 12'h000;
      bar = c / 40;
      px  = c % 40;
      if (bar >= 16 || px >= 36) return 12'h000;
      m = shown[bar];
      if (m > 480) m = 480;
      if (m == 0 || r < 480 - m) return 12'h000;
      return (r < 120) ? 12'hF00 : 12'h0F0;
   endfunction

   // ---------------- driver ----------------
   // One pixel clock: check what has come out, then present the next input
   // and record what it must produce PIPE_LATENCY clocks later.
   task automatic tick(input int r, input int c, input bit wen, input int widx,
                       input int wmag, input bit cmt);
      logic [14:0] e;
      bit dv, hs, vs, fp;
      @(negedge clk);
      check_eq("swap_pending", 32'(swap_pending), 32'(m_pend));
      if (exp_q.size() >= PIPE_LATENCY) begin
         e = exp_q.pop_front();
         check_eq("pixel", 32'({vga_r, vga_g, vga_b, hsync, vsync, de}), 32'(e));
      end
      dv = (r >= 0 && r < 480 && c < 640);
      hs = !(c >= 648 && c < 656);
      vs = !(r >= 490 && r < 492);
      fp = (r == 0 && c == 0);
      row         = 16'(r);
      col         = 16'(c);
      de_in       = dv;
      hsync_in    = hs;
      vsync_in    = vs;
      frame_pulse = fp;
      bin_wr_en   = wen;
      bin_wr_idx  = 4'(widx);
      bin_wr_mag  = 9'(wmag);
      bin_commit  = cmt;
      if (fp && m_pend) begin
         for (int i = 0; i < 16; i++) begin
            int t;
            t          = shown[i];
            shown[i]   = pending[i];
            pending[i] = t;
         end
         m_pend = 1'b0;
      end
      if (wen && widx < 16) pending[widx] = wmag;
      if (cmt) m_pend = 1'b1;
      exp_q.push_back({ref_rgb(r, c, dv), hs, vs, dv});
   endtask

   task automatic drive_idle();
      row = 16'sd500; col = '0;
      hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0; frame_pulse = 1'b0;
      bin_wr_en = 1'b0; bin_wr_idx = '0; bin_wr_mag = '0; bin_commit = 1'b0;
   endtask

   // Asynchronous reset away from the clock edge; outputs must go idle at once.
   task automatic do_reset();
      @(negedge clk);
      #2;
      resetn = 1'b0;
      drive_idle();
      #1;
      check_eq("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
      check_eq("rst_hsync", 32'(hsync), 32'h1);
      check_eq("rst_vsync", 32'(vsync), 32'h1);
      check_eq("rst_de", 32'(de), 32'h0);
      check_eq("rst_pending", 32'(swap_pending), 32'h0);
      repeat (3) @(negedge clk);
      check_eq("rst_hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
      check_eq("rst_hold_sync", 32'({hsync, vsync, de}), 32'h6);
      resetn = 1'b1;
      model_reset();
   endtask

   // One frame of selected lines. Directed events can be placed on the
   // frame-pulse cycle and mid-frame (line 2); rnd adds random traffic;
   // rst_line >= 0 aborts the frame with a reset on that line.
   task automatic run_frame(input bit fp_wen, input int fp_idx, input int fp_mag, input bit fp_cmt,
                            input bit mid_wen, input int mid_idx, input int mid_mag, input bit mid_cmt,
                            input bit rnd, input int rst_line);
      int rows[NROWS];
      rows[0] = 0;   rows[1] = 119; rows[2] = 120; rows[3] = $urandom_range(1, 478);
      rows[4] = 359; rows[5] = 360; rows[6] = 479; rows[7] = 490;
      for (int li = 0; li < NROWS; li++) begin
         for (int c = 0; c < LINE_LEN; c++) begin
            bit wen, cmt;
            int idx, mag;
            wen = 1'b0; cmt = 1'b0; idx = 0; mag = 0;
            if (rnd) begin
               if ($urandom_range(0, 63) == 0) begin
                  wen = 1'b1;
                  idx = $urandom_range(0, 15);
                  mag = $urandom_range(0, 511);
               end
               if ($urandom_range(0, 1999) == 0) cmt = 1'b1;
            end
            if (li == 0 && c == 0) begin
               wen = fp_wen; idx = fp_idx; mag = fp_mag; cmt = fp_cmt;
            end
            if (li == 2 && c == 300 && mid_wen) begin
               wen = 1'b1; idx = mid_idx; mag = mid_mag;
            end
            if (li == 2 && c == 301 && mid_cmt) cmt = 1'b1;
            if (li == rst_line && c == 200) begin
               do_reset();
               return;
            end
            tick(rows[li], c, wen, idx, mag, cmt);
         end
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      drive_idle();
      model_reset();
      do_reset();
      // All bins zero; bin 3 = 120 written and committed, nothing shown yet.
      run_frame(0, 0, 0, 0,   1, 3, 120, 1,   0, -1);
      // Single bar 3 on screen; stage bin 0 = 500 (clamps to full height).
      run_frame(0, 0, 0, 0,   1, 0, 500, 1,   0, -1);
      // Bin 0 full height, red/green split; stage bin 5 = 240 mid-frame.
      run_frame(0, 0, 0, 0,   1, 5, 240, 1,   0, -1);
      // Bin 5 appears; stage bin 7 = 300 and commit.
      run_frame(0, 0, 0, 0,   1, 7, 300, 1,   0, -1);
      // Swap on this pulse while committing and writing bin 2 = 60.
      run_frame(1, 2, 60, 1,  0, 0, 0, 0,     0, -1);
      // Pending commit from the pulse cycle swaps here: bin 2 shown.
      run_frame(0, 0, 0, 0,   0, 0, 0, 0,     0, -1);
      // Random traffic.
      for (int f = 0; f < 2; f++) begin
         run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 511),
                   1'($urandom_range(0, 1)),
                   1'b1, $urandom_range(0, 15), $urandom_range(0, 511), 1'b1, 1, -1);
      end
      // Reset in the middle of a line of a lit frame.
      run_frame(0, 0, 0, 0,   1, 9, 400, 1,   1, 6);
      // After reset: dark until a commit and swap, then bin 4 = 480.
      run_frame(0, 0, 0, 0,   1, 4, 480, 1,   0, -1);
      run_frame(0, 0, 0, 0,   0, 0, 0, 0,     0, -1);
      // Drain the pipeline.
      for (int i = 0; i < PIPE_LATENCY + 1; i++) begin
         tick(500, i, 0, 0, 0, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
